// File: rtl/adc_st_pkg.sv
// Shared constants and types for the ADC Avalon-ST packetizer.
// A beat packs 16 samples with the first sample in the top lane.
package adc_st_pkg;
   localparam int SAMPLE_W = 32;
   localparam int LANES    = 16;
   localparam int DATA_W   = SAMPLE_W * LANES;
   localparam int EMPTY_W  = 6;
   localparam int LEN_W    = 16;
   localparam int LANE_W   = $clog2(LANES);

   typedef enum logic [1:0] {IDLE, FILL, HOLD, DRAIN} state_e;

   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic               sop;
      logic               eop;
      logic [EMPTY_W-1:0] empty;
   } beat_t;
endpackage

// File: rtl/st_beat_fifo.sv
// Two-entry first-word-fall-through beat buffer.
// When full, a push is accepted in the same cycle as a pop.
module st_beat_fifo
   import adc_st_pkg::*;
(
   input  logic  clk,
   input  logic  reset_n,
   input  logic  push_i,
   input  beat_t din_i,
   input  logic  pop_i,
   output beat_t dout_o,
   output logic  full_o,
   output logic  empty_o
);
   beat_t      mem_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;
   logic       do_push;
   logic       do_pop;

   assign do_pop  = pop_i && (count_q != 2'd0);
   assign do_push = push_i && ((count_q != 2'd2) || do_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
endmodule

// File: rtl/adc_st_packetizer.sv
// Packs free-running ADC samples into 512-bit Avalon-ST beats, one packet per arm.
// A beat that cannot enter the buffer is held; samples arriving meanwhile are dropped and flagged.
module adc_st_packetizer
   import adc_st_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                arm,
   input  logic [LEN_W-1:0]    pkt_len,
   input  logic [SAMPLE_W-1:0] adc_data,
   input  logic                adc_valid,
   output logic [DATA_W-1:0]   src_data,
   output logic                src_valid,
   input  logic                src_ready,
   output logic                src_startofpacket,
   output logic                src_endofpacket,
   output logic [EMPTY_W-1:0]  src_empty,
   output logic                busy,
   output logic                overflow,
   input  logic                clear_ovf,
   output logic [31:0]         pkt_count
);
   state_e                            state_q;
   logic [LEN_W-1:0]                  len_q;
   logic [LEN_W-1:0]                  smp_cnt_q;
   logic [LANE_W-1:0]                 lane_cnt_q;
   logic [LANES-1:0][SAMPLE_W-1:0]    asm_q;
   logic [LANES-1:0][SAMPLE_W-1:0]    asm_d;
   logic                              first_q;
   logic                              busy_q;
   logic                              ovf_q;
   logic [31:0]                       pkt_cnt_q;
   beat_t                             hold_q;

   logic  last_smp;
   logic  beat_done;
   logic  fifo_full;
   logic  fifo_empty;
   logic  pop;
   logic  can_push;
   logic  push;
   beat_t fill_beat;
   beat_t push_beat;
   beat_t head;

   // Lane 0 occupies the top 32 bits of the beat.
   always_comb begin
      asm_d = asm_q;
      asm_d[LANE_W'(LANES-1) - lane_cnt_q] = adc_data;
   end

   assign last_smp  = (smp_cnt_q + LEN_W'(1)) == len_q;
   assign beat_done = adc_valid && ((lane_cnt_q == LANE_W'(LANES-1)) || last_smp);
   assign pop       = !fifo_empty && src_ready;
   assign can_push  = !fifo_full || pop;

   always_comb begin
      fill_beat.data  = asm_d;
      fill_beat.sop   = first_q;
      fill_beat.eop   = last_smp;
      fill_beat.empty = last_smp ? {~lane_cnt_q, 2'b00} : '0;
   end

   always_comb begin
      push      = 1'b0;
      push_beat = fill_beat;
      case (state_q)
         FILL: push = beat_done && can_push;
         HOLD: begin
            push      = can_push;
            push_beat = hold_q;
         end
         default: push = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         smp_cnt_q  <= '0;
         lane_cnt_q <= '0;
         asm_q      <= '0;
         first_q    <= 1'b0;
         busy_q     <= 1'b0;
         ovf_q      <= 1'b0;
         pkt_cnt_q  <= '0;
         hold_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arm && (pkt_len != '0)) begin
                  len_q      <= pkt_len;
                  smp_cnt_q  <= '0;
                  lane_cnt_q <= '0;
                  asm_q      <= '0;
                  first_q    <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= FILL;
               end
            end
            FILL: begin
               if (adc_valid) begin
                  smp_cnt_q <= smp_cnt_q + LEN_W'(1);
                  if (beat_done) begin
                     asm_q      <= '0;
                     lane_cnt_q <= '0;
                     first_q    <= 1'b0;
                     if (can_push) begin
                        state_q <= last_smp ? DRAIN : FILL;
                     end else begin
                        hold_q  <= fill_beat;
                        state_q <= HOLD;
                     end
                  end else begin
                     asm_q      <= asm_d;
                     lane_cnt_q <= lane_cnt_q + LANE_W'(1);
                  end
               end
            end
            HOLD: begin
               if (can_push) begin
                  state_q <= hold_q.eop ? DRAIN : FILL;
               end
            end
            DRAIN: begin
               if (pop && head.eop) begin
                  busy_q    <= 1'b0;
                  pkt_cnt_q <= pkt_cnt_q + 32'd1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         // A drop in the same cycle as clear_ovf keeps the flag set.
         if ((state_q == HOLD) && adc_valid) begin
            ovf_q <= 1'b1;
         end else if (clear_ovf) begin
            ovf_q <= 1'b0;
         end
      end
   end

   st_beat_fifo u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push),
      .din_i   (push_beat),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign src_data          = head.data;
   assign src_valid         = !fifo_empty;
   assign src_startofpacket = head.sop;
   assign src_endofpacket   = head.eop;
   assign src_empty         = head.empty;
   assign busy              = busy_q;
   assign overflow          = ovf_q;
   assign pkt_count         = pkt_cnt_q;
endmodule
